// File: rtl/cell_local_packetizer.sv
// Local FOFB packetizer: on each FA strobe emits header, BPM payload from readout RAM and trailer on AXI-Stream.
// Optional build macro CELL_PACKETIZER_TIMESTAMP_EN adds a cycle-counter STAMP word before the trailer.
module cell_local_packetizer #(
  parameter int MAX_BPMS         = 32,
  parameter int CELL_INDEX_WIDTH = 5
) (
  input  logic                        auroraUserClk,
  input  logic                        auroraResetN,
  input  logic                        auroraFAstrobe,
  input  logic [CELL_INDEX_WIDTH-1:0] cellIndex,
  input  logic [5:0]                  bpmCount,
  input  logic                        readoutValid,
  output logic [6:0]                  rdAddr,
  input  logic [31:0]                 rdData,
  output logic                        localTxTVALID,
  output logic                        localTxTLAST,
  input  logic                        localTxTREADY,
  output logic [31:0]                 localTxTDATA,
  output logic [7:0]                  missedStrobes
);

`ifdef CELL_PACKETIZER_TIMESTAMP_EN
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, STAMP, TRAILER} state_t;
  localparam state_t     AFTER_PAYLOAD = STAMP;
  localparam logic [9:0] STAMP_WORDS   = 10'd1;
`else
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
  localparam state_t     AFTER_PAYLOAD = TRAILER;
  localparam logic [9:0] STAMP_WORDS   = 10'd0;
`endif

  state_t                      state;
  logic [CELL_INDEX_WIDTH-1:0] cellIdxQ;
  logic [6:0]                  nWords;
  logic [6:0]                  issuedCnt;
  logic [6:0]                  beatsLeft;
  logic                        badQ;
  logic [15:0]                 seqCnt;
  logic                        issueNow;
  logic                        inflight;
  logic [31:0]                 fifoMem [2];
  logic                        fifoRdPtr;
  logic                        fifoWrPtr;
  logic [1:0]                  fifoCount;
  logic [31:0]                 stampQ;

  logic [6:0]  nClamp;
  logic [6:0]  nWordsNew;
  logic [31:0] headerWord;
  logic        beat;
  logic        startPkt;
  logic        missed;
  logic        consumedPayload;
  logic        popFifo;
  logic        pushFifo;
  logic [2:0]  occ;
  logic        issueNext;

  assign nClamp    = (7'(bpmCount) > 7'(MAX_BPMS)) ? 7'(MAX_BPMS) : 7'(bpmCount);
  assign nWordsNew = {nClamp[5:0], 1'b0};

  assign beat     = localTxTVALID && localTxTREADY;
  // A strobe landing on the trailer handshake is treated as arriving in IDLE.
  assign startPkt = auroraFAstrobe && (state == IDLE || (state == TRAILER && beat));
  assign missed   = auroraFAstrobe && !startPkt;

  // Payload beats come from the buffer head, or straight from the RAM when the buffer is empty.
  assign consumedPayload = beat && (state == PAYLOAD);
  assign popFifo         = consumedPayload && (fifoCount != 2'd0);
  assign pushFifo        = inflight && !(consumedPayload && fifoCount == 2'd0);

  // Words owed to the buffer (stored, returning, being read) after this cycle's consumption;
  // a new read is only issued if its data is guaranteed a free slot on return.
  assign occ       = 3'(fifoCount) + 3'(inflight) + 3'(issueNow) - 3'(consumedPayload);
  assign issueNext = (issuedCnt < nWords) && (occ <= 3'd1);

  always_comb begin
    headerWord                          = '0;
    headerWord[31:16]                   = 16'hA5BE;
    headerWord[10 +: CELL_INDEX_WIDTH]  = cellIdxQ;
    headerWord[9:0]                     = {3'b000, nWords} + STAMP_WORDS;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    localTxTVALID = 1'b0;
    localTxTLAST  = 1'b0;
    localTxTDATA  = '0;
    case (state)
      HEADER: begin
        localTxTVALID = 1'b1;
        localTxTDATA  = headerWord;
      end
      PAYLOAD: begin
        localTxTVALID = (fifoCount != 2'd0) || inflight;
        localTxTDATA  = (fifoCount != 2'd0) ? fifoMem[fifoRdPtr] : rdData;
      end
`ifdef CELL_PACKETIZER_TIMESTAMP_EN
      STAMP: begin
        localTxTVALID = 1'b1;
        localTxTDATA  = stampQ;
      end
`endif
      TRAILER: begin
        localTxTVALID = 1'b1;
        localTxTLAST  = 1'b1;
        localTxTDATA  = {badQ, 15'd0, seqCnt};
      end
      default: ;
    endcase
  end

  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!auroraResetN) begin
      state         <= IDLE;
      cellIdxQ      <= '0;
      nWords        <= '0;
      issuedCnt     <= '0;
      beatsLeft     <= '0;
      badQ          <= 1'b0;
      seqCnt        <= '0;
      issueNow      <= 1'b0;
      inflight      <= 1'b0;
      fifoRdPtr     <= 1'b0;
      fifoWrPtr     <= 1'b0;
      fifoCount     <= '0;
      rdAddr        <= '0;
      missedStrobes <= '0;
    end else begin
      inflight  <= issueNow;
      issueNow  <= 1'b0;
      fifoCount <= fifoCount + 2'(pushFifo) - 2'(popFifo);
      if (pushFifo) fifoWrPtr <= ~fifoWrPtr;
      if (popFifo)  fifoRdPtr <= ~fifoRdPtr;

      if (issueNext) begin
        rdAddr    <= issuedCnt;
        issuedCnt <= issuedCnt + 7'd1;
        issueNow  <= 1'b1;
      end

      if (missed) begin
        if (missedStrobes != 8'hFF) missedStrobes <= missedStrobes + 8'd1;
        // Once the trailer is on the bus its data must stay stable, so it is no longer marked.
        if (state != TRAILER) badQ <= 1'b1;
      end

      case (state)
        HEADER: if (beat) begin
          if (nWords == 7'd0) begin
            state <= AFTER_PAYLOAD;
          end else begin
            state     <= PAYLOAD;
            beatsLeft <= nWords;
          end
        end
        PAYLOAD: if (beat) begin
          beatsLeft <= beatsLeft - 7'd1;
          if (beatsLeft == 7'd1) state <= AFTER_PAYLOAD;
        end
`ifdef CELL_PACKETIZER_TIMESTAMP_EN
        STAMP: if (beat) state <= TRAILER;
`endif
        TRAILER: if (beat) begin
          seqCnt <= seqCnt + 16'd1;
          state  <= IDLE;
        end
        default: ;
      endcase

      if (startPkt) begin
        state     <= HEADER;
        cellIdxQ  <= cellIndex;
        nWords    <= nWordsNew;
        badQ      <= !readoutValid || (nClamp == 7'd0);
        rdAddr    <= '0;
        issuedCnt <= (nWordsNew != 7'd0) ? 7'd1 : 7'd0;
        issueNow  <= (nWordsNew != 7'd0);
        inflight  <= 1'b0;
        fifoCount <= '0;
        fifoRdPtr <= 1'b0;
        fifoWrPtr <= 1'b0;
      end
    end
  end

  // NOTE: the buffer storage is pure datapath guarded by fifoCount, so it carries no reset.
  always_ff @(posedge auroraUserClk) begin
    if (pushFifo) fifoMem[fifoWrPtr] <= rdData;
  end

`ifdef CELL_PACKETIZER_TIMESTAMP_EN
  logic [31:0] cycleCnt;

  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      cycleCnt <= '0;
      stampQ   <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (startPkt) stampQ <= cycleCnt;
    end
  end
`else
  assign stampQ = '0;
`endif

endmodule

// File: tb/tb_cell_local_packetizer.sv
// Directed self-checking bench for cell_local_packetizer: packet content, stalls, clamping, overrun, reset.
module tb_cell_local_packetizer;
`ifdef CELL_PACKETIZER_TIMESTAMP_EN
  localparam int STAMP = 1;
`else
  localparam int STAMP = 0;
`endif

  logic        auroraUserClk = 1'b0;
  logic        auroraResetN  = 1'b0;
  logic        auroraFAstrobe = 1'b0;
  logic [4:0]  cellIndex = '0;
  logic [5:0]  bpmCount = '0;
  logic        readoutValid = 1'b0;
  logic [6:0]  rdAddr;
  logic [31:0] rdData = '0;
  logic        localTxTVALID;
  logic        localTxTLAST;
  logic        localTxTREADY = 1'b0;
  logic [31:0] localTxTDATA;
  logic [7:0]  missedStrobes;

  cell_local_packetizer #(.MAX_BPMS(32), .CELL_INDEX_WIDTH(5)) dut (
    .auroraUserClk (auroraUserClk),
    .auroraResetN  (auroraResetN),
    .auroraFAstrobe(auroraFAstrobe),
    .cellIndex     (cellIndex),
    .bpmCount      (bpmCount),
    .readoutValid  (readoutValid),
    .rdAddr        (rdAddr),
    .rdData        (rdData),
    .localTxTVALID (localTxTVALID),
    .localTxTLAST  (localTxTLAST),
    .localTxTREADY (localTxTREADY),
    .localTxTDATA  (localTxTDATA),
    .missedStrobes (missedStrobes)
  );

  always #5 auroraUserClk = ~auroraUserClk;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [128];
  always @(posedge auroraUserClk) rdData <= ram[rdAddr];

  // readyMode: 0 = held low, 1 = held high, 2 = pseudo-random
  int readyMode = 1;
  always @(posedge auroraUserClk) begin
    #2;
    case (readyMode)
      0:       localTxTREADY = 1'b0;
      1:       localTxTREADY = 1'b1;
      default: localTxTREADY = 1'($urandom_range(0, 1));
    endcase
  end

  logic [31:0] tbCycles;
  always @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) tbCycles <= '0;
    else               tbCycles <= tbCycles + 32'd1;
  end

  // Beat recorder and stall-stability watcher, sampled mid-cycle.
  logic [31:0] beats[$];
  logic        lasts[$];
  int          beatCyc[$];
  int          cyc = 0;
  int          stallErr = 0;
  int          maxAddr = 0;
  logic        prevStall = 1'b0;
  logic [31:0] prevData = '0;
  logic        prevLast = 1'b0;

  always @(negedge auroraUserClk) begin
    cyc++;
    if (!auroraResetN) begin
      prevStall = 1'b0;
    end else if (localTxTVALID) begin
      if (prevStall && (localTxTDATA !== prevData || localTxTLAST !== prevLast)) stallErr++;
      if (localTxTREADY) begin
        beats.push_back(localTxTDATA);
        lasts.push_back(localTxTLAST);
        beatCyc.push_back(cyc);
      end
      prevStall = !localTxTREADY;
      prevData  = localTxTDATA;
      prevLast  = localTxTLAST;
    end else begin
      if (prevStall) stallErr++;
      prevStall = 1'b0;
    end
    if (int'(rdAddr) > maxAddr) maxAddr = int'(rdAddr);
  end

  task automatic doStrobe(input logic [4:0] ci, input logic [5:0] bc, input logic rv);
    cellIndex      = ci;
    bpmCount       = bc;
    readoutValid   = rv;
    auroraFAstrobe = 1'b1;
    @(posedge auroraUserClk);
    #1;
    auroraFAstrobe = 1'b0;
    cellIndex      = 5'd0;
    bpmCount       = 6'd63;
    readoutValid   = 1'b0;
  endtask

  task automatic waitBeats(input int want, input int budget, output bit ok);
    int n = 0;
    while (beats.size() < want && n < budget) begin
      @(posedge auroraUserClk);
      n++;
    end
    #1;
    ok = (beats.size() >= want);
  endtask

  task automatic test_reset;
    auroraResetN = 1'b0;
    repeat (3) @(posedge auroraUserClk);
    @(negedge auroraUserClk);
    total++; if (localTxTVALID !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", localTxTVALID); end
    total++; if (localTxTLAST !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", localTxTLAST); end
    total++; if (localTxTDATA !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h want 00000000", localTxTDATA); end
    total++; if (rdAddr !== 7'd0) begin bad++; $display("FAIL reset_rdaddr: got %0d want 0", rdAddr); end
    total++; if (missedStrobes !== 8'd0) begin bad++; $display("FAIL reset_missed: got %0d want 0", missedStrobes); end
    auroraResetN = 1'b1;
    repeat (2) @(posedge auroraUserClk);
    @(negedge auroraUserClk);
    total++; if (localTxTVALID !== 1'b0) begin bad++; $display("FAIL idle_tvalid: got %b want 0", localTxTVALID); end
    @(posedge auroraUserClk);
    #1;
  endtask

  task automatic test_basic;
    int  b0;
    bit  ok;
    int  nb;
    int  lastCount;
    b0 = beats.size();
    doStrobe(5'd5, 6'd3, 1'b1);
    @(negedge auroraUserClk);
    total++; if (localTxTVALID !== 1'b1) begin bad++; $display("FAIL basic_hdr_latency: tvalid got %b want 1", localTxTVALID); end
    total++; if (rdAddr !== 7'd0) begin bad++; $display("FAIL basic_rdaddr0: got %0d want 0", rdAddr); end
    nb = 8 + STAMP;
    waitBeats(b0 + nb, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_count: got %0d want %0d", beats.size() - b0, nb); end
    if (ok) begin
      total++; if (beats[b0] !== 32'hA5BE1406 + STAMP) begin bad++; $display("FAIL basic_header: got %h want %h", beats[b0], 32'hA5BE1406 + STAMP); end
      for (int k = 0; k < 6; k++) begin
        total++;
        if (beats[b0 + 1 + k] !== 32'h1000 + k) begin bad++; $display("FAIL basic_payload%0d: got %h want %h", k, beats[b0 + 1 + k], 32'h1000 + k); end
      end
      total++; if (beats[b0 + nb - 1] !== 32'h00000000) begin bad++; $display("FAIL basic_trailer: got %h want 00000000", beats[b0 + nb - 1]); end
      lastCount = 0;
      for (int k = 0; k < nb; k++) if (lasts[b0 + k] === 1'b1) lastCount++;
      total++; if (lastCount !== 1 || lasts[b0 + nb - 1] !== 1'b1) begin bad++; $display("FAIL basic_tlast: got %0d last beats, final=%b want 1,1", lastCount, lasts[b0 + nb - 1]); end
      total++; if (beatCyc[b0 + nb - 1] - beatCyc[b0] !== nb - 1) begin bad++; $display("FAIL basic_no_bubbles: got span %0d want %0d", beatCyc[b0 + nb - 1] - beatCyc[b0], nb - 1); end
    end
    b0 = beats.size();
    doStrobe(5'd5, 6'd3, 1'b1);
    waitBeats(b0 + nb, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic2_count: got %0d want %0d", beats.size() - b0, nb); end
    if (ok) begin
      total++; if (beats[b0 + nb - 1] !== 32'h00000001) begin bad++; $display("FAIL basic2_trailer: got %h want 00000001", beats[b0 + nb - 1]); end
    end
  endtask

  task automatic test_stalls;
    int b0;
    bit ok;
    int nb;
    nb = 8 + STAMP;
    readyMode = 2;
    b0 = beats.size();
    doStrobe(5'd5, 6'd3, 1'b1);
    waitBeats(b0 + nb, 500, ok);
    readyMode = 1;
    total++; if (!ok) begin bad++; $display("FAIL stall_count: got %0d want %0d", beats.size() - b0, nb); end
    if (ok) begin
      total++; if (beats[b0] !== 32'hA5BE1406 + STAMP) begin bad++; $display("FAIL stall_header: got %h want %h", beats[b0], 32'hA5BE1406 + STAMP); end
      for (int k = 0; k < 6; k++) begin
        total++;
        if (beats[b0 + 1 + k] !== 32'h1000 + k) begin bad++; $display("FAIL stall_payload%0d: got %h want %h", k, beats[b0 + 1 + k], 32'h1000 + k); end
      end
      total++; if (beats[b0 + nb - 1] !== 32'h00000002) begin bad++; $display("FAIL stall_trailer: got %h want 00000002", beats[b0 + nb - 1]); end
    end
    total++; if (stallErr !== 0) begin bad++; $display("FAIL stall_stable: got %0d unstable beats want 0", stallErr); end
    total++; if (maxAddr > 5) begin bad++; $display("FAIL stall_rdaddr_max: got %0d want <=5", maxAddr); end
    @(posedge auroraUserClk);
    #1;
  endtask

  task automatic test_empty_and_clamp;
    int b0;
    bit ok;
    b0 = beats.size();
    doStrobe(5'd5, 6'd0, 1'b1);
    waitBeats(b0 + 2 + STAMP, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL empty_count: got %0d want %0d", beats.size() - b0, 2 + STAMP); end
    if (ok) begin
      total++; if (beats[b0] !== 32'hA5BE1400 + STAMP) begin bad++; $display("FAIL empty_header: got %h want %h", beats[b0], 32'hA5BE1400 + STAMP); end
      total++; if (beats[b0 + 1 + STAMP] !== 32'h80000003) begin bad++; $display("FAIL empty_trailer: got %h want 80000003", beats[b0 + 1 + STAMP]); end
      total++; if (lasts[b0 + 1 + STAMP] !== 1'b1) begin bad++; $display("FAIL empty_tlast: got %b want 1", lasts[b0 + 1 + STAMP]); end
    end
    b0 = beats.size();
    doStrobe(5'd5, 6'd40, 1'b1);
    waitBeats(b0 + 66 + STAMP, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_count: got %0d want %0d", beats.size() - b0, 66 + STAMP); end
    if (ok) begin
      total++; if (beats[b0] !== 32'hA5BE1440 + STAMP) begin bad++; $display("FAIL clamp_header: got %h want %h", beats[b0], 32'hA5BE1440 + STAMP); end
      total++; if (beats[b0 + 64] !== 32'h0000103F) begin bad++; $display("FAIL clamp_last_payload: got %h want 0000103f", beats[b0 + 64]); end
      total++; if (beats[b0 + 65 + STAMP] !== 32'h00000004) begin bad++; $display("FAIL clamp_trailer: got %h want 00000004", beats[b0 + 65 + STAMP]); end
    end
  endtask

  task automatic test_overrun;
    int b0;
    bit ok;
    readyMode = 0;
    @(posedge auroraUserClk);
    #1;
    b0 = beats.size();
    doStrobe(5'd5, 6'd32, 1'b1);
    repeat (20) @(posedge auroraUserClk);
    #1;
    doStrobe(5'd7, 6'd1, 1'b1);
    @(negedge auroraUserClk);
    total++; if (missedStrobes !== 8'd1) begin bad++; $display("FAIL overrun_missed_now: got %0d want 1", missedStrobes); end
    total++; if (beats.size() !== b0) begin bad++; $display("FAIL overrun_no_beats_while_stalled: got %0d want 0", beats.size() - b0); end
    repeat (78) @(posedge auroraUserClk);
    #1;
    readyMode = 1;
    waitBeats(b0 + 66 + STAMP, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL overrun_count: got %0d want %0d", beats.size() - b0, 66 + STAMP); end
    if (ok) begin
      total++; if (beats[b0] !== 32'hA5BE1440 + STAMP) begin bad++; $display("FAIL overrun_header: got %h want %h", beats[b0], 32'hA5BE1440 + STAMP); end
      total++; if (beats[b0 + 64] !== 32'h0000103F) begin bad++; $display("FAIL overrun_last_payload: got %h want 0000103f", beats[b0 + 64]); end
      total++; if (beats[b0 + 65 + STAMP] !== 32'h80000005) begin bad++; $display("FAIL overrun_trailer: got %h want 80000005", beats[b0 + 65 + STAMP]); end
    end
    repeat (5) @(posedge auroraUserClk);
    #1;
    total++; if (beats.size() !== b0 + 66 + STAMP) begin bad++; $display("FAIL overrun_no_extra_packet: got %0d want %0d", beats.size() - b0, 66 + STAMP); end
    total++; if (missedStrobes !== 8'd1) begin bad++; $display("FAIL overrun_missed: got %0d want 1", missedStrobes); end
    total++; if (stallErr !== 0) begin bad++; $display("FAIL overrun_stable: got %0d unstable beats want 0", stallErr); end
  endtask

  task automatic test_back_to_back;
    int b0;
    bit ok;
    int nb;
    nb = 4 + STAMP;
    b0 = beats.size();
    doStrobe(5'd5, 6'd1, 1'b1);
    repeat (3 + STAMP) @(posedge auroraUserClk);
    #1;
    doStrobe(5'd5, 6'd1, 1'b1);
    waitBeats(b0 + 2 * nb, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_count: got %0d want %0d", beats.size() - b0, 2 * nb); end
    if (ok) begin
      total++; if (beats[b0 + nb - 1] !== 32'h00000006) begin bad++; $display("FAIL b2b_trailer1: got %h want 00000006", beats[b0 + nb - 1]); end
      total++; if (beats[b0 + nb] !== 32'hA5BE1402 + STAMP) begin bad++; $display("FAIL b2b_header2: got %h want %h", beats[b0 + nb], 32'hA5BE1402 + STAMP); end
      total++; if (beatCyc[b0 + nb] - beatCyc[b0 + nb - 1] !== 1) begin bad++; $display("FAIL b2b_gap: got %0d want 1", beatCyc[b0 + nb] - beatCyc[b0 + nb - 1]); end
      total++; if (beats[b0 + 2 * nb - 1] !== 32'h00000007) begin bad++; $display("FAIL b2b_trailer2: got %h want 00000007", beats[b0 + 2 * nb - 1]); end
    end
    total++; if (missedStrobes !== 8'd1) begin bad++; $display("FAIL b2b_missed: got %0d want 1", missedStrobes); end
  endtask

  task automatic test_reset_mid;
    int b0;
    bit ok;
    int nb;
    nb = 8 + STAMP;
    b0 = beats.size();
    doStrobe(5'd5, 6'd3, 1'b1);
    repeat (3) @(posedge auroraUserClk);
    #2;
    total++; if (beats.size() - b0 !== 3) begin bad++; $display("FAIL rstmid_beats_before: got %0d want 3", beats.size() - b0); end
    auroraResetN = 1'b0;
    #1;
    total++; if (localTxTVALID !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid: got %b want 0", localTxTVALID); end
    total++; if (localTxTDATA !== 32'h0) begin bad++; $display("FAIL rstmid_tdata: got %h want 00000000", localTxTDATA); end
    total++; if (rdAddr !== 7'd0) begin bad++; $display("FAIL rstmid_rdaddr: got %0d want 0", rdAddr); end
    total++; if (missedStrobes !== 8'd0) begin bad++; $display("FAIL rstmid_missed: got %0d want 0", missedStrobes); end
    @(posedge auroraUserClk);
    #1;
    auroraResetN = 1'b1;
    @(posedge auroraUserClk);
    #1;
    b0 = beats.size();
    doStrobe(5'd5, 6'd3, 1'b1);
    waitBeats(b0 + nb, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_count: got %0d want %0d", beats.size() - b0, nb); end
    if (ok) begin
      total++; if (beats[b0] !== 32'hA5BE1406 + STAMP) begin bad++; $display("FAIL rstmid_header: got %h want %h", beats[b0], 32'hA5BE1406 + STAMP); end
      total++; if (beats[b0 + 3] !== 32'h00001002) begin bad++; $display("FAIL rstmid_payload2: got %h want 00001002", beats[b0 + 3]); end
      total++; if (beats[b0 + nb - 1] !== 32'h00000000) begin bad++; $display("FAIL rstmid_trailer: got %h want 00000000", beats[b0 + nb - 1]); end
    end
  endtask

  task automatic test_timestamp;
`ifdef CELL_PACKETIZER_TIMESTAMP_EN
    int          b0;
    bit          ok;
    logic [31:0] stampExp;
    b0 = beats.size();
    stampExp = tbCycles;
    doStrobe(5'd5, 6'd2, 1'b1);
    waitBeats(b0 + 7, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL stamp_count: got %0d want 7", beats.size() - b0); end
    if (ok) begin
      total++; if (beats[b0] !== 32'hA5BE1405) begin bad++; $display("FAIL stamp_header: got %h want a5be1405", beats[b0]); end
      total++; if (beats[b0 + 5] !== stampExp) begin bad++; $display("FAIL stamp_value: got %h want %h", beats[b0 + 5], stampExp); end
      total++; if (beats[b0 + 6] !== 32'h00000001) begin bad++; $display("FAIL stamp_trailer: got %h want 00000001", beats[b0 + 6]); end
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 32'h1000 + i;
    test_reset;
    test_basic;
    test_stalls;
    test_empty_and_clamp;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    test_timestamp;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
